uart_tx_frame: RTL

Parametrised UART transmitter: the next generation of the team's fixed 8N1 transmitter. It accepts a parallel word over a valid/ready handshake and serialises it as a complete asynchronous frame: start bit, 5–9 data bits, optional parity and 1 or 2 stop bits. Bit timing comes from a single-cycle baud tick enable in the system clock domain, not a separate baud clock. It sits between the TX FIFO read side and the pad.

---
 rtl/uart_tx_frame_pkg.sv | 38 +++
 rtl/uart_tx_frame_if.sv | 12 +
 rtl/uart_tx_frame.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: parity modes, TX state encoding and frame-format limits.
// Used by the transmitter now and by the parametrised receiver later.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  // dataXor is the XOR of all data bits; odd parity inverts it so the frame has an odd count of ones.
  function automatic logic parityBit(input int mode, input logic dataXor);
    if (mode == PAR_ODD)  return ~dataXor;
    if (mode == PAR_EVEN) return dataXor;
    return 1'b0;
  endfunction

  function automatic bit frameParamsLegal(input int dataBits, input int parityMode,
                                          input int stopBits, input int msbFirst);
    return (dataBits >= DATA_BITS_MIN) && (dataBits <= DATA_BITS_MAX) &&
           (stopBits >= STOP_BITS_MIN) && (stopBits <= STOP_BITS_MAX) &&
           (parityMode >= PAR_NONE) && (parityMode <= PAR_EVEN) &&
           ((msbFirst == 0) || (msbFirst == 1));
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Word handshake between the TX FIFO read side and the UART transmitter.
// The transmitter is the slave: it raises oTX_READY only while idle.
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 iTX_VALID;
  logic [DATA_BITS-1:0] iTX_FIFO_DATA;
  logic                 oTX_READY;

  modport master (output iTX_VALID, output iTX_FIFO_DATA, input oTX_READY);
  modport slave  (input iTX_VALID, input iTX_FIFO_DATA, output oTX_READY);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word per valid/ready handshake and sends start/data/parity/stop, one bit per iBAUD_TICK.
// Line is registered; the start bit begins at the first tick after accept; oTX_READY stays low until the last stop tick.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = PAR_NONE,
  parameter int STOP_BITS   = 1,
  parameter int MSB_FIRST   = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           iBAUD_TICK,
  uart_tx_frame_if.slave txIf,
  output logic           oTX_DATA,
  output logic           oTX_BUSY,
  output logic           oTX_DONE
);

  localparam int CNT_W = $clog2(DATA_BITS);

  if (!frameParamsLegal(DATA_BITS, PARITY_MODE, STOP_BITS, MSB_FIRST)) begin : gBadParams
    $error("uart_tx_frame: illegal frame format parameters");
  end

  txState_t             state, stateNxt;
  logic [DATA_BITS-1:0] shiftReg, shiftNxt, shifted;
  logic [CNT_W-1:0]     bitCnt, bitCntNxt;
  logic                 stopCnt, stopCntNxt;
  logic                 parReg, parNxt;
  logic                 lineNxt, doneNxt;
  logic                 accept, nextBit;

  assign txIf.oTX_READY = (state == IDLE);
  assign accept         = txIf.iTX_VALID && txIf.oTX_READY;
  // The done cycle is already IDLE but still counts as busy.
  assign oTX_BUSY       = (state != IDLE) || oTX_DONE;

  if (MSB_FIRST != 0) begin : gMsbFirst
    assign nextBit = shiftReg[DATA_BITS-1];
    assign shifted = {shiftReg[DATA_BITS-2:0], 1'b0};
  end else begin : gLsbFirst
    assign nextBit = shiftReg[0];
    assign shifted = {1'b0, shiftReg[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
      stopCnt  <= 1'b0;
      parReg   <= 1'b0;
      oTX_DATA <= 1'b1;
      oTX_DONE <= 1'b0;
    end else begin
      state    <= stateNxt;
      shiftReg <= shiftNxt;
      bitCnt   <= bitCntNxt;
      stopCnt  <= stopCntNxt;
      parReg   <= parNxt;
      oTX_DATA <= lineNxt;
      oTX_DONE <= doneNxt;
    end
  end

  always_comb begin
    stateNxt   = state;
    shiftNxt   = shiftReg;
    bitCntNxt  = bitCnt;
    stopCntNxt = stopCnt;
    parNxt     = parReg;
    lineNxt    = oTX_DATA;
    doneNxt    = 1'b0;
    case (state)
      IDLE: begin
        lineNxt = 1'b1;
        if (accept) begin
          shiftNxt = txIf.iTX_FIFO_DATA;
          parNxt   = parityBit(PARITY_MODE, ^txIf.iTX_FIFO_DATA);
          stateNxt = ARM;
        end
      end
      ARM: begin
        if (iBAUD_TICK) begin
          stateNxt = START;
          lineNxt  = 1'b0;
        end
      end
      START: begin
        if (iBAUD_TICK) begin
          stateNxt  = DATA;
          lineNxt   = nextBit;
          shiftNxt  = shifted;
          bitCntNxt = CNT_W'(DATA_BITS - 1);
        end
      end
      DATA: begin
        if (iBAUD_TICK) begin
          if (bitCnt == '0) begin
            if (PARITY_MODE != PAR_NONE) begin
              stateNxt = PARITY;
              lineNxt  = parReg;
            end else begin
              stateNxt   = STOP;
              lineNxt    = 1'b1;
              stopCntNxt = 1'(STOP_BITS - 1);
            end
          end else begin
            lineNxt   = nextBit;
            shiftNxt  = shifted;
            bitCntNxt = bitCnt - CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (iBAUD_TICK) begin
          stateNxt   = STOP;
          lineNxt    = 1'b1;
          stopCntNxt = 1'(STOP_BITS - 1);
        end
      end
      STOP: begin
        if (iBAUD_TICK) begin
          if (stopCnt == 1'b0) begin
            stateNxt = IDLE;
            doneNxt  = 1'b1;
          end else begin
            stopCntNxt = 1'b0;
          end
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule
